// File: rtl/ser_pkg.sv
// Shared types and defaults for the byte serializer.
// Timer width and the load-value helper live here so both modules agree.
package ser_pkg;

    localparam int unsigned TIMER_W          = 16;
    localparam int unsigned DEF_HIGH_CYCLES  = 10;
    localparam int unsigned DEF_LOW_CYCLES   = 10;
    localparam int unsigned DEF_GAP_CYCLES   = 300;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_STATUS,
        BIT_HIGH,
        BIT_LOW,
        GAP
    } ser_state_t;

    // A phase of N cycles loads N-1 and ends when the timer reads 0.
    function automatic logic [TIMER_W-1:0] dur_to_load(input int unsigned cycles);
        return TIMER_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/ser_timer.sv
// Loadable down-counter with terminal count, shared by all timed phases.
// Load wins over counting; the count parks at zero.
module ser_timer
    import ser_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] load_val_i,
    output logic               tc_o
);

    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TIMER_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/serializer.sv
// Byte-to-strobed-serial converter, MSB first, with a downstream status gate
// and a fixed inter-word gap.
module serializer
    import ser_pkg::*;
#(
    parameter int unsigned HIGH_CYCLES = DEF_HIGH_CYCLES,
    parameter int unsigned LOW_CYCLES  = DEF_LOW_CYCLES,
    parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    input  logic       status_in,
    output logic       data_out,
    output logic       write_out,
    output logic       busy_out,
    output logic [7:0] sent_count_out
);

    ser_state_t         state_q, state_d;
    logic [7:0]         shift_q, shift_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_val;
    logic               tmr_tc;

    ser_timer u_timer (
        .clock      (clock),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .tc_o       (tmr_tc)
    );

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            IDLE: begin
                if (valid_in) begin
                    shift_d = data_in;
                    idx_d   = '0;
                    state_d = WAIT_STATUS;
                end
            end
            WAIT_STATUS: begin
                if (status_in) begin
                    state_d  = BIT_HIGH;
                    tmr_load = 1'b1;
                    tmr_val  = dur_to_load(HIGH_CYCLES);
                end
            end
            BIT_HIGH: begin
                if (tmr_tc) begin
                    state_d  = BIT_LOW;
                    tmr_load = 1'b1;
                    tmr_val  = dur_to_load(LOW_CYCLES);
                end
            end
            BIT_LOW: begin
                if (tmr_tc) begin
                    shift_d  = {shift_q[6:0], 1'b0};
                    idx_d    = idx_q + 3'd1;
                    tmr_load = 1'b1;
                    if (idx_q == 3'd7) begin
                        state_d = GAP;
                        tmr_val = dur_to_load(GAP_CYCLES);
                    end else begin
                        state_d = BIT_HIGH;
                        tmr_val = dur_to_load(HIGH_CYCLES);
                    end
                end
            end
            GAP: begin
                if (tmr_tc) begin
                    state_d = IDLE;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // The shift register only moves after BIT_LOW, so its MSB is the live bit.
    assign data_out       = shift_q[7];
    assign write_out      = (state_q == BIT_HIGH);
    assign ready_out      = (state_q == IDLE);
    assign busy_out       = (state_q != IDLE);
    assign sent_count_out = cnt_q;

endmodule

// File: tb/tb_serializer.sv
// Randomized self-checking bench for the serializer against a word-timing model.
// Short phase lengths keep a 256-word wrap run fast.
module tb_serializer;

    localparam int H    = 4;
    localparam int L    = 3;
    localparam int G    = 20;
    localparam int P    = H + L;
    localparam int WORD = 8 * P + G;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       status_in;
    logic       data_out;
    logic       write_out;
    logic       busy_out;
    logic [7:0] sent_count_out;

    serializer #(
        .HIGH_CYCLES (H),
        .LOW_CYCLES  (L),
        .GAP_CYCLES  (G)
    ) dut (
        .clock          (clk),
        .reset          (reset),
        .data_in        (data_in),
        .valid_in       (valid_in),
        .ready_out      (ready_out),
        .status_in      (status_in),
        .data_out       (data_out),
        .write_out      (write_out),
        .busy_out       (busy_out),
        .sent_count_out (sent_count_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Word-level model: idle, waiting on status, or sending with a cycle offset.
    typedef enum int { M_IDLE, M_WAIT, M_SEND } mmode_t;
    mmode_t     m_mode = M_IDLE;
    int         m_t    = 0;
    int         m_cnt  = 0;
    logic [7:0] m_byte = '0;
    bit         armed  = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_mode = M_IDLE;
            m_t    = 0;
            m_cnt  = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (valid_in) begin
                    m_byte = data_in;
                    m_mode = M_WAIT;
                end
                M_WAIT: if (status_in) begin
                    m_mode = M_SEND;
                    m_t    = 0;
                end
                M_SEND: begin
                    m_t++;
                    if (m_t == WORD) begin
                        m_mode = M_IDLE;
                        m_cnt  = (m_cnt + 1) % 256;
                    end
                end
                default: m_mode = M_IDLE;
            endcase
        end
    end

    // Receiver side: rebuild bytes from strobes and measure pulse widths.
    int         nb      = 0;
    logic [7:0] rx_sh   = '0;
    logic [7:0] last_rx = '0;
    logic [7:0] rx_q[$];
    bit         wr_prev = 0;
    int         hi_len  = 0;
    int         lo_len  = 0;
    int         last_hi = 0;
    int         last_lo = 0;

    always @(negedge clk) begin
        logic exp_w;
        if (armed) begin
            exp_w = (m_mode == M_SEND) && (m_t < 8 * P) && ((m_t % P) < H);
            chk("write_out", write_out, exp_w);
            chk("ready_out", ready_out, m_mode == M_IDLE);
            chk("busy_out", busy_out, m_mode != M_IDLE);
            chk("sent_count", sent_count_out, m_cnt);
            if (exp_w)
                chk("data_out", data_out, (m_byte >> (7 - m_t / P)) & 8'd1);
        end
        if (reset) begin
            nb = 0;
        end else if (write_out && !wr_prev) begin
            rx_sh = {rx_sh[6:0], data_out};
            nb++;
            if (nb == 8) begin
                last_rx = rx_sh;
                rx_q.push_back(rx_sh);
                chk("word", rx_sh, m_byte);
                nb = 0;
            end
        end
        if (write_out) begin
            if (!wr_prev && lo_len > 0) last_lo = lo_len;
            hi_len++;
            lo_len = 0;
        end else begin
            if (wr_prev) last_hi = hi_len;
            hi_len = 0;
            lo_len++;
        end
        wr_prev = write_out;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting, got none expected event", name);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready_out && n < 5000) begin
            step();
            n++;
        end
        if (!ready_out) timeout("wait_ready");
    endtask

    int wr_wait  = 0;
    int idle_cnt = 0;

    task automatic send_word(input logic [7:0] b, input int delay);
        wait_ready();
        data_in   = b;
        valid_in  = 1'b1;
        status_in = (delay == 0);
        step();
        valid_in = 1'b0;
        wr_wait  = 0;
        idle_cnt = 0;
        for (int i = 0; i < delay; i++) begin
            if (write_out) wr_wait++;
            if (!busy_out) idle_cnt++;
            step();
        end
        status_in = 1'b1;
    endtask

    task automatic wait_nb(input int k);
        int n = 0;
        while (nb != k && n < 2000) begin
            step();
            n++;
        end
        if (nb != k) timeout("wait_nb");
    endtask

    initial begin
        int e;
        reset     = 1'b1;
        valid_in  = 1'b0;
        data_in   = '0;
        status_in = 1'b1;
        step();
        armed = 1;
        step();
        reset = 1'b0;
        chk("rst_ready", ready_out, 1);
        chk("rst_busy", busy_out, 0);
        chk("rst_write", write_out, 0);
        chk("rst_count", sent_count_out, 0);

        // Single 0x80 word: acceptance edge, then status edge plus 76 cycles.
        send_word(8'h80, 0);
        e = 0;
        while (sent_count_out != 8'd1 && e < 500) begin
            step();
            e++;
        end
        chk("word80_edges", e, 77);
        chk("word80_rx", last_rx, 8'h80);
        chk("pulse_high", last_hi, 4);
        chk("pulse_low", last_lo, 3);

        // Status held low for 50 cycles after acceptance.
        send_word(8'hA5, 50);
        chk("a5_no_write", wr_wait, 0);
        chk("a5_busy", idle_cnt, 0);
        wait_ready();
        chk("a5_rx", last_rx, 8'hA5);

        // Status drop during bit 3 completes the word, stalls the next.
        send_word(8'h3C, 0);
        wait_nb(4);
        status_in = 1'b0;
        wait_ready();
        chk("3c_rx", last_rx, 8'h3C);
        chk("3c_count", sent_count_out, 3);
        send_word(8'h11, 30);
        chk("stall_no_write", wr_wait, 0);
        chk("stall_busy", idle_cnt, 0);
        wait_ready();
        chk("11_rx", last_rx, 8'h11);

        // Nine bytes with valid held high throughout.
        rx_q.delete();
        valid_in  = 1'b1;
        status_in = 1'b1;
        for (int k = 0; k < 9; k++) begin
            data_in = 8'h80 + 8'(k);
            wait_ready();
            step();
        end
        valid_in = 1'b0;
        wait_ready();
        chk("burst_len", rx_q.size(), 9);
        for (int k = 0; k < 9; k++) begin
            logic [7:0] got;
            got = (k < rx_q.size()) ? rx_q[k] : 8'h00;
            chk("burst_byte", got, 8'h80 + 8'(k));
        end
        chk("burst_count", sent_count_out, 13);

        // Reset during bit 5, with valid also asserted on the reset edge.
        send_word(8'hC3, 0);
        wait_nb(6);
        reset    = 1'b1;
        valid_in = 1'b1;
        data_in  = 8'hFF;
        step();
        reset    = 1'b0;
        valid_in = 1'b0;
        chk("mid_rst_write", write_out, 0);
        chk("mid_rst_count", sent_count_out, 0);
        chk("mid_rst_ready", ready_out, 1);
        send_word(8'h5A, 0);
        wait_ready();
        chk("after_rst_rx", last_rx, 8'h5A);
        chk("after_rst_count", sent_count_out, 1);

        // Random traffic up to the counter wrap.
        for (int i = 1; i < 255; i++) begin
            send_word(8'($urandom_range(0, 255)),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0);
            repeat ($urandom_range(0, 2)) step();
        end
        wait_ready();
        chk("count_255", sent_count_out, 255);
        send_word(8'($urandom_range(0, 255)), 0);
        wait_ready();
        chk("count_wrap", sent_count_out, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
